// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers, one bit per cycle.
// Define MULDIV_DIVZERO_FAST_EN to finish divide-by-zero straight from IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opd;
  logic               is_div, neg_q, neg_r, dz;
  logic               a_neg, b_neg, b_zero, fast_dz, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign accept = (state == IDLE) & start;

`ifdef MULDIV_DIVZERO_FAST_EN
  assign fast_dz = op[1] & b_zero;
`else
  assign fast_dz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast_dz ? DONE : CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // acc_hi/acc_lo: partial product + multiplier for MUL, remainder + dividend/quotient for DIV
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opd};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= op[1] ? a_mag : b_mag;
      opd      <= op[1] ? b_mag : a_mag;
      is_div   <= op[1];
      // a zero divisor yields an all-ones quotient that must not be sign-fixed
      neg_q    <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
      neg_r    <= a_neg;
      dz       <= op[1] & b_zero;
      div_zero <= 1'b0;
      if (fast_dz) begin
        hi       <= a;
        lo       <= '1;
        div_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (is_div) begin
        if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end else if (state == FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        {hi, lo} <= prod_fix;
      end
      div_zero <= dz;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded directed bench for muldiv_unit at WIDTH=32; a negedge monitor checks results and latency.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;
`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = LAT;
`endif

  logic         clk, rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic [63:0] p;
    z = 1'b0;
    if (!o[1]) begin
      if (o[0]) p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      else      p = {32'h0, x} * {32'h0, y};
      {h, l} = p;
    end else if (y == 0) begin
      h = x; l = '1; z = 1'b1;
    end else if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      h = '0; l = x;
    end else if (o[0]) begin
      l = $signed(x) / $signed(y);
      h = $signed(x) % $signed(y);
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                       input int lat, input string tag);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    e.hi = eh; e.lo = el; e.dz = ez; e.lat = lat; e.acc = cyc; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * LAT && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input string tag);
    logic [W-1:0] h, l;
    logic z;
    model(o, x, y, h, l, z);
    issue(o, x, y, h, l, z, (o[1] && y == 0) ? DZ_LAT : LAT, tag);
    wait_idle();
  endtask

  // Scoreboard monitor: compares on done, checks busy every cycle, flags missing/extra done.
  always @(negedge clk) begin
    int cur, c;
    cur = cyc + 1;
    cyc <= cur;
    if (rst) begin
      check("busy_done_overlap", 64'(busy & done), 64'd0);
      if (sb.size() != 0) begin
        c = cur - sb[0].acc;
        if (done) begin
          check({sb[0].tag, "_hi"}, 64'(hi), 64'(sb[0].hi));
          check({sb[0].tag, "_lo"}, 64'(lo), 64'(sb[0].lo));
          check({sb[0].tag, "_dz"}, 64'(div_zero), 64'(sb[0].dz));
          check({sb[0].tag, "_lat"}, 64'(c), 64'(sb[0].lat));
          void'(sb.pop_front());
        end else if (c > sb[0].lat) begin
          check({sb[0].tag, "_timeout"}, 64'(c), 64'(sb[0].lat));
          void'(sb.pop_front());
        end else begin
          check({sb[0].tag, "_busy"}, 64'(busy), 64'd1);
        end
      end else begin
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT, "multu_max");
    wait_idle();
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT, "mult_neg");
    wait_idle();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT, "div_neg");
    wait_idle();
    issue(2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, DZ_LAT, "divu_zero");
    wait_idle();
    repeat (3) @(negedge clk);
    check("dz_sticky", 64'(div_zero), 64'd1);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, LAT, "div_ovf");
    check("dz_cleared", 64'(div_zero), 64'd0);
    wait_idle();
    issue(2'b11, 32'h8000_0005, 32'd0, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1, DZ_LAT, "div_zero_neg");
    wait_idle();

    // start during a running op must be ignored
    issue(2'b00, 32'd12345, 32'd678, 32'h0, 32'd8369910, 1'b0, LAT, "ignore_start");
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd999; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    a = 32'h5555_5555; b = 32'h1234_5678; op = 2'b01;
    repeat (5) @(negedge clk);
    check("hold_hi", 64'(hi), 64'd0);
    check("hold_lo", 64'(lo), 64'd8369910);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (i >= 4) ? W'($urandom_range(1, 300)) : W'($urandom);
      if (i == 5) y = -y;
      run_model(2'(i % 4), x, y, $sformatf("rand%0d", i));
    end

    // reset in the middle of a multiply
    issue(2'b01, 32'h0012_3456, 32'hFFFF_0001, 32'h0, 32'h0, 1'b0, LAT, "aborted");
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_hi", 64'(hi), 64'd0);
    run_model(2'b10, 32'd1000, 32'd7, "after_rst");
    run_model(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, "mult_extremes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO register width; legal range 8..64, even.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  WIDTH  multiplicand / dividend.
REQ-007 b  input  WIDTH  multiplier / divisor.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
REQ-010 div_zero  output  1  sticky flag: last completed divide had b==0; cleared by the next accepted start.
REQ-011 hi  output  WIDTH  HI register: product upper half / remainder.
REQ-012 lo  output  WIDTH  LO register: product lower half / quotient.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 a, b and op are latched on the accepting edge; later changes do not affect the running operation.
REQ-015 Signed ops convert operands to magnitudes on accept; FIX applies the result sign.
REQ-016 Multiply: radix-2 shift-add, one bit per CALC cycle; 2*WIDTH-bit result, HI = upper half, LO = lower half.
REQ-017 Divide: restoring, one quotient bit per CALC cycle; quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-018 Latency: done is high exactly WIDTH+2 cycles after the accepting edge. With WIDTH=32, done is high in cycle 34.
REQ-019 hi/lo update only on entry to DONE and otherwise hold their value indefinitely.
REQ-020 start while busy or in DONE is ignored; there is no queueing.
REQ-021 Divide by zero (b==0): lo = all ones, hi = a unchanged, div_zero = 1.
REQ-022 Signed overflow (DIV, a = most-negative, b = -1): lo = most-negative, hi = 0, div_zero = 0.
REQ-023 busy and done are never high in the same cycle.

Reset
REQ-024 Reset asserted: FSM -> IDLE; busy, done, div_zero, hi and lo = 0 immediately, without waiting for a clock edge.
REQ-025 Reset mid-operation aborts the operation: no done pulse, and partial results are never visible on hi/lo.
REQ-026 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro MULDIV_DIVZERO_FAST_EN, when defined: a divide with b==0 skips CALC and FIX (IDLE->DONE); done is high 1 cycle after the accepting edge with the REQ-021 result.
REQ-028 Without MULDIV_DIVZERO_FAST_EN: divide by zero takes the full WIDTH+2 cycles; results are identical.

Verification (WIDTH=32)
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1..33.
REQ-030 MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero=1; done in cycle 1 with the macro, cycle 34 without.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-033 Second start pulsed with different operands in cycle 10 of a running op -> ignored; the result matches the first op; hi/lo hold the first result until a start is accepted after done.
REQ-034 rst low in cycle 15 of a multiply -> hi=lo=0 and busy=0 asynchronously; no done pulse ever appears; a new op after release completes normally.
